// File: rtl/signal_gen_ctrl_pkg.sv
// Shared types and host register map for the
// signal generator controller.
package signal_gen_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_SWAP = 2'd3
  } state_e;

  localparam int MSG_WORDS_DEF = 5;

  localparam int A_SV       = 0;
  localparam int A_FCARR_LO = 1;
  localparam int A_FCARR_HI = 2;
  localparam int A_FCODE_LO = 3;
  localparam int A_FCODE_HI = 4;
  localparam int A_PCAR_LO  = 5;
  localparam int A_PCAR_HI  = 6;
  localparam int A_PCOD_LO  = 7;
  localparam int A_PCOD_HI  = 8;
  localparam int A_CODECNT  = 9;
  localparam int A_NAVI     = 10;
  localparam int A_MSG      = 11;
  localparam int A_FLAGS    = 31;

endpackage

// File: rtl/signal_gen_ctrl_msg_dbuf.sv
// Pending/active navigation message double buffer.
// Pending is host-written in 32-bit halves; copy moves it to active.
module msg_dbuf
  import signal_gen_ctrl_pkg::*;
#(
  parameter int MSG_WORDS = MSG_WORDS_DEF,
  parameter int HW = $clog2(2 * MSG_WORDS)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [HW-1:0]            wr_idx_i,
  input  logic [31:0]              wr_data_i,
  input  logic                     commit_i,
  input  logic                     copy_i,
  output logic                     valid_o,
  output logic                     overwrite_o,
  output logic [64*MSG_WORDS-1:0]  active_o
);

  logic [2*MSG_WORDS-1:0][31:0] pend_q;
  logic [64*MSG_WORDS-1:0]      act_q;
  logic                         valid_q;
  logic                         valid_d;

  // A commit landing on the copy cycle re-arms the buffer.
  always_comb begin
    valid_d = valid_q;
    if (copy_i) begin
      valid_d = commit_i;
    end else if (commit_i) begin
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q  <= '0;
      act_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr_en_i) pend_q[wr_idx_i] <= wr_data_i;
      if (copy_i) act_q <= pend_q;
      valid_q <= valid_d;
    end
  end

  assign valid_o     = valid_q;
  assign overwrite_o = commit_i & valid_q & ~copy_i;
  assign active_o    = act_q;

endmodule

// File: rtl/signal_gen_ctrl.sv
// Host controller for the signal generator: config registers,
// run FSM and subframe-synchronous message hand-off.
module signal_gen_ctrl
  import signal_gen_ctrl_pkg::*;
#(
  parameter int MSG_WORDS = MSG_WORDS_DEF,
  parameter int AW = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [31:0]             wr_data,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    msg_commit,
  input  logic                    time6s_sign,
  output logic                    send_en,
  output logic [5:0]              sv_num,
  output logic [61:0]             fcarr_control,
  output logic [61:0]             fcode_control,
  output logic [62:0]             phase_init_carrier,
  output logic [62:0]             phase_init_code,
  output logic [14:0]             phase_init_navidata,
  output logic [8:0]              address_init_navidata,
  output logic [9:0]              code_cnt_init,
  output logic [64*MSG_WORDS-1:0] message_flat,
  output logic                    shut_time6s_sign,
  output logic                    msg_req,
  output logic [1:0]              state_o,
  output logic                    underrun,
  output logic                    overwrite,
  output logic                    cmd_err
);

  localparam int HW = $clog2(2 * MSG_WORDS);

  state_e      state_q;
  logic        send_q, shut_q, req_q, t6_q;
  logic        underrun_q, overwrite_q, cmd_err_q;
  logic [5:0]  sv_q;
  logic [61:0] fcarr_q, fcode_q;
  logic [62:0] pcar_q, pcod_q;
  logic [14:0] pnav_q;
  logic [8:0]  anav_q;
  logic [9:0]  ccnt_q;

  logic [31:0]   addr_w;
  logic [HW-1:0] msg_idx;
  logic cfg_wr, cfg_ok, msg_wr, clr_wr;
  logic pend_valid, ovw_w, copy_w, edge_w;

  assign addr_w  = 32'(wr_addr);
  assign msg_idx = HW'(addr_w - 32'(A_MSG));
  assign cfg_wr  = wr_en && (addr_w <= 32'(A_NAVI));
  assign cfg_ok  = cfg_wr && (state_q == S_IDLE);
  assign msg_wr  = wr_en && (addr_w >= 32'(A_MSG))
                && (addr_w < 32'(A_MSG + 2 * MSG_WORDS));
  assign clr_wr  = wr_en && (addr_w == 32'(A_FLAGS)) && wr_data[0];
  assign edge_w  = time6s_sign & ~t6_q;
  assign copy_w  = !stop && pend_valid
                && (state_q == S_LOAD || state_q == S_SWAP);

  msg_dbuf #(.MSG_WORDS(MSG_WORDS)) u_dbuf (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr_en_i     (msg_wr),
    .wr_idx_i    (msg_idx),
    .wr_data_i   (wr_data),
    .commit_i    (msg_commit),
    .copy_i      (copy_w),
    .valid_o     (pend_valid),
    .overwrite_o (ovw_w),
    .active_o    (message_flat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sv_q    <= '0;
      fcarr_q <= '0;
      fcode_q <= '0;
      pcar_q  <= '0;
      pcod_q  <= '0;
      pnav_q  <= '0;
      anav_q  <= '0;
      ccnt_q  <= '0;
    end else if (cfg_ok) begin
      case (addr_w)
        32'(A_SV):       sv_q          <= wr_data[5:0];
        32'(A_FCARR_LO): fcarr_q[31:0] <= wr_data;
        32'(A_FCARR_HI): fcarr_q[61:32] <= wr_data[29:0];
        32'(A_FCODE_LO): fcode_q[31:0] <= wr_data;
        32'(A_FCODE_HI): fcode_q[61:32] <= wr_data[29:0];
        32'(A_PCAR_LO):  pcar_q[31:0]  <= wr_data;
        32'(A_PCAR_HI):  pcar_q[62:32] <= wr_data[30:0];
        32'(A_PCOD_LO):  pcod_q[31:0]  <= wr_data;
        32'(A_PCOD_HI):  pcod_q[62:32] <= wr_data[30:0];
        32'(A_CODECNT): begin
          ccnt_q <= wr_data[18:9];
          anav_q <= wr_data[8:0];
        end
        32'(A_NAVI):     pnav_q        <= wr_data[14:0];
        default: ;
      endcase
    end
  end

  // Flag clear comes first so a same-cycle set still sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      send_q      <= 1'b0;
      shut_q      <= 1'b0;
      req_q       <= 1'b0;
      t6_q        <= 1'b0;
      underrun_q  <= 1'b0;
      overwrite_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      t6_q   <= time6s_sign;
      shut_q <= 1'b0;
      req_q  <= 1'b0;
      if (clr_wr) begin
        underrun_q  <= 1'b0;
        overwrite_q <= 1'b0;
        cmd_err_q   <= 1'b0;
      end
      if (cfg_wr && state_q != S_IDLE) cmd_err_q <= 1'b1;
      if (ovw_w) overwrite_q <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            if (pend_valid) begin
              state_q <= S_LOAD;
              req_q   <= 1'b1;
            end else begin
              cmd_err_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (stop) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_RUN;
            send_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_q <= S_IDLE;
            send_q  <= 1'b0;
          end else if (edge_w) begin
            state_q <= S_SWAP;
            shut_q  <= 1'b1;
            req_q   <= 1'b1;
          end
        end
        S_SWAP: begin
          if (stop) begin
            state_q <= S_IDLE;
            send_q  <= 1'b0;
          end else begin
            state_q <= S_RUN;
            if (!pend_valid) underrun_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign send_en               = send_q;
  assign shut_time6s_sign      = shut_q;
  assign msg_req               = req_q;
  assign state_o               = state_q;
  assign underrun              = underrun_q;
  assign overwrite             = overwrite_q;
  assign cmd_err               = cmd_err_q;
  assign sv_num                = sv_q;
  assign fcarr_control         = fcarr_q;
  assign fcode_control         = fcode_q;
  assign phase_init_carrier    = pcar_q;
  assign phase_init_code       = pcod_q;
  assign phase_init_navidata   = pnav_q;
  assign address_init_navidata = anav_q;
  assign code_cnt_init         = ccnt_q;

endmodule

// File: tb/tb_signal_gen_ctrl.sv
// Scoreboard bench for signal_gen_ctrl: expected messages are queued
// at start/edge stimulus and compared when msg_req fires.
module tb_signal_gen_ctrl;

  localparam int MW = 5;
  localparam int AW = 5;
  localparam int MB = 64 * MW;

  logic          clk = 1'b0;
  logic          rst, wr_en, start, stop, msg_commit, time6s_sign;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          send_en, shut_time6s_sign, msg_req;
  logic          underrun, overwrite, cmd_err;
  logic [5:0]    sv_num;
  logic [61:0]   fcarr_control, fcode_control;
  logic [62:0]   phase_init_carrier, phase_init_code;
  logic [14:0]   phase_init_navidata;
  logic [8:0]    address_init_navidata;
  logic [9:0]    code_cnt_init;
  logic [MB-1:0] message_flat;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  signal_gen_ctrl #(.MSG_WORDS(MW), .AW(AW)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .wr_en                 (wr_en),
    .wr_addr               (wr_addr),
    .wr_data               (wr_data),
    .start                 (start),
    .stop                  (stop),
    .msg_commit            (msg_commit),
    .time6s_sign           (time6s_sign),
    .send_en               (send_en),
    .sv_num                (sv_num),
    .fcarr_control         (fcarr_control),
    .fcode_control         (fcode_control),
    .phase_init_carrier    (phase_init_carrier),
    .phase_init_code       (phase_init_code),
    .phase_init_navidata   (phase_init_navidata),
    .address_init_navidata (address_init_navidata),
    .code_cnt_init         (code_cnt_init),
    .message_flat          (message_flat),
    .shut_time6s_sign      (shut_time6s_sign),
    .msg_req               (msg_req),
    .state_o               (state_o),
    .underrun              (underrun),
    .overwrite             (overwrite),
    .cmd_err               (cmd_err)
  );

  typedef struct {
    logic [MB-1:0] msg;
    logic          shut;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  bit   chk_next = 0;
  int   checks = 0;
  int   errors = 0;
  int   req_cnt = 0;
  int   shut_cnt = 0;

  logic [MB-1:0] m_pend = '0;
  logic [MB-1:0] m_act = '0;
  bit            m_valid = 0;

  always @(negedge clk) begin
    if (rst) begin
      chk_next = 0;
    end else begin
      if (chk_next) begin
        chk_next = 0;
        checks++;
        if (message_flat !== cur.msg) begin
          errors++;
          $display("FAIL sb_msg: got %h want %h", message_flat, cur.msg);
        end
      end
      if (shut_time6s_sign) shut_cnt++;
      if (msg_req) begin
        req_cnt++;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_req: got msg_req=1 want 0");
        end else begin
          cur = sbq.pop_front();
          if (shut_time6s_sign !== cur.shut) begin
            errors++;
            $display("FAIL sb_shut: got %0b want %0b",
                     shut_time6s_sign, cur.shut);
          end
          chk_next = 1;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input int a, input logic [31:0] d);
    wr_en = 1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic pulse(input bit s, input bit p, input bit c);
    start = s; stop = p; msg_commit = c;
    tick();
    start = 0; stop = 0; msg_commit = 0;
  endtask

  task automatic write_word(input int k, input logic [63:0] w);
    host_wr(11 + 2 * k, w[31:0]);
    host_wr(12 + 2 * k, w[63:32]);
    m_pend[64*k +: 64] = w;
  endtask

  task automatic commit();
    pulse(0, 0, 1);
    m_valid = 1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    tick(2);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d left want 0", nm, sbq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0;
    start = 0; stop = 0; msg_commit = 0; time6s_sign = 0;
    tick(2);
    checks++;
    if (send_en !== 1'b0) begin
      errors++; $display("FAIL rst_send: got %0b want 0", send_en);
    end
    checks++;
    if (state_o !== 2'd0) begin
      errors++; $display("FAIL rst_state: got %0d want 0", state_o);
    end
    checks++;
    if (message_flat !== '0 || sv_num !== '0 || fcarr_control !== '0) begin
      errors++; $display("FAIL rst_data: got %h want 0", message_flat);
    end
    checks++;
    if ({msg_req, shut_time6s_sign, underrun, overwrite, cmd_err}
        !== 5'b0) begin
      errors++; $display("FAIL rst_flags: got %b want 0",
        {msg_req, shut_time6s_sign, underrun, overwrite, cmd_err});
    end
    rst = 0;
    tick();
  endtask

  task automatic test_start();
    logic [61:0] f, g;
    logic [62:0] pc, pk;
    int r0;
    f  = 62'd301936306998477940;
    g  = 62'h2AAA_BBBB_CCCC_DDDD;
    pc = 63'h1234_5678_9ABC_DEF0;
    pk = 63'h7FED_CBA9_8765_4321;
    host_wr(0, 32'hFFFF_FFC3);
    host_wr(1, f[31:0]);
    host_wr(2, {2'b11, f[61:32]});
    host_wr(3, g[31:0]);
    host_wr(4, {2'b01, g[61:32]});
    host_wr(5, pc[31:0]);
    host_wr(6, {1'b1, pc[62:32]});
    host_wr(7, pk[31:0]);
    host_wr(8, {1'b0, pk[62:32]});
    host_wr(9, {13'h1ABC, 10'h2A5, 9'h1C3});
    host_wr(10, {17'h1FFFF, 15'h5A5A});
    write_word(0, 64'h22c05614257709a0);
    write_word(4, 64'hDEAD_BEEF_0123_4567);
    commit();
    r0 = req_cnt;
    sbq.push_back('{m_pend, 1'b0});
    m_act = m_pend;
    m_valid = 0;
    pulse(1, 0, 0);
    checks++;
    if (state_o !== 2'd1 || send_en !== 1'b0) begin
      errors++; $display("FAIL start_load: got st=%0d en=%0b want 1/0",
                         state_o, send_en);
    end
    tick();
    checks++;
    if (state_o !== 2'd2 || send_en !== 1'b1) begin
      errors++; $display("FAIL start_run: got st=%0d en=%0b want 2/1",
                         state_o, send_en);
    end
    checks++;
    if (sv_num !== 6'd3 || fcarr_control !== f || fcode_control !== g) begin
      errors++; $display("FAIL start_freq: got %0d %h %h want 3 %h %h",
                         sv_num, fcarr_control, fcode_control, f, g);
    end
    checks++;
    if (phase_init_carrier !== pc || phase_init_code !== pk) begin
      errors++; $display("FAIL start_phase: got %h %h want %h %h",
                         phase_init_carrier, phase_init_code, pc, pk);
    end
    checks++;
    if (code_cnt_init !== 10'h2A5 || address_init_navidata !== 9'h1C3
        || phase_init_navidata !== 15'h5A5A) begin
      errors++; $display("FAIL start_nav: got %h %h %h want 2a5 1c3 5a5a",
        code_cnt_init, address_init_navidata, phase_init_navidata);
    end
    drain("start");
    checks++;
    if (req_cnt - r0 !== 1) begin
      errors++; $display("FAIL start_req: got %0d want 1", req_cnt - r0);
    end
  endtask

  task automatic test_swap();
    int r0, s0;
    write_word(0, 64'h0123_4567_89AB_CDEF);
    write_word(1, 64'hFEDC_BA98_7654_3210);
    commit();
    r0 = req_cnt; s0 = shut_cnt;
    sbq.push_back('{m_pend, 1'b1});
    m_act = m_pend;
    m_valid = 0;
    time6s_sign = 1;
    tick();
    checks++;
    if (state_o !== 2'd3 || shut_time6s_sign !== 1'b1) begin
      errors++; $display("FAIL swap_enter: got st=%0d shut=%0b want 3/1",
                         state_o, shut_time6s_sign);
    end
    tick();
    checks++;
    if (state_o !== 2'd2 || shut_time6s_sign !== 1'b0 || send_en !== 1) begin
      errors++; $display("FAIL swap_exit: got st=%0d shut=%0b want 2/0",
                         state_o, shut_time6s_sign);
    end
    tick(3);
    time6s_sign = 0;
    tick();
    drain("swap");
    checks++;
    if (shut_cnt - s0 !== 1 || req_cnt - r0 !== 1) begin
      errors++; $display("FAIL swap_pulses: got %0d/%0d want 1/1",
                         shut_cnt - s0, req_cnt - r0);
    end
    checks++;
    if (underrun !== 1'b0 || message_flat !== m_act || sv_num !== 6'd3) begin
      errors++; $display("FAIL swap_state: got ur=%0b sv=%0d want 0/3",
                         underrun, sv_num);
    end
  endtask

  task automatic test_underrun();
    int s0;
    s0 = shut_cnt;
    sbq.push_back('{m_act, 1'b1});
    time6s_sign = 1;
    tick();
    time6s_sign = 0;
    tick(3);
    drain("underrun");
    checks++;
    if (underrun !== 1'b1 || shut_cnt - s0 !== 1) begin
      errors++; $display("FAIL underrun: got ur=%0b shut=%0d want 1/1",
                         underrun, shut_cnt - s0);
    end
    checks++;
    if (message_flat !== m_act || state_o !== 2'd2) begin
      errors++; $display("FAIL underrun_msg: got %h want %h",
                         message_flat, m_act);
    end
  endtask

  task automatic test_commit_on_swap();
    host_wr(31, 32'h1);
    checks++;
    if (underrun !== 1'b0 || cmd_err !== 1'b0) begin
      errors++; $display("FAIL flag_clear: got ur=%0b ce=%0b want 0/0",
                         underrun, cmd_err);
    end
    write_word(2, 64'h5555_AAAA_3333_CCCC);
    commit();
    sbq.push_back('{m_pend, 1'b1});
    m_act = m_pend;
    time6s_sign = 1;
    tick();
    msg_commit = 1; time6s_sign = 0;
    tick();
    msg_commit = 0;
    tick(2);
    sbq.push_back('{m_pend, 1'b1});
    time6s_sign = 1;
    tick();
    time6s_sign = 0;
    tick(3);
    drain("commit_swap");
    m_valid = 0;
    checks++;
    if (underrun !== 1'b0 || message_flat !== m_act) begin
      errors++; $display("FAIL commit_swap: got ur=%0b want 0", underrun);
    end
  endtask

  task automatic test_cmd_err();
    host_wr(0, 32'd7);
    checks++;
    if (sv_num !== 6'd3 || cmd_err !== 1'b1) begin
      errors++; $display("FAIL cfg_in_run: got sv=%0d ce=%0b want 3/1",
                         sv_num, cmd_err);
    end
    pulse(0, 1, 0);
    checks++;
    if (state_o !== 2'd0 || send_en !== 1'b0) begin
      errors++; $display("FAIL stop: got st=%0d en=%0b want 0/0",
                         state_o, send_en);
    end
    host_wr(31, 32'h1);
    pulse(1, 0, 0);
    tick();
    checks++;
    if (state_o !== 2'd0 || send_en !== 1'b0 || cmd_err !== 1'b1) begin
      errors++; $display("FAIL start_empty: got st=%0d ce=%0b want 0/1",
                         state_o, cmd_err);
    end
    host_wr(0, 32'd9);
    checks++;
    if (sv_num !== 6'd9) begin
      errors++; $display("FAIL cfg_idle: got %0d want 9", sv_num);
    end
  endtask

  task automatic test_overwrite();
    host_wr(31, 32'h1);
    write_word(3, 64'h1111_2222_3333_4444);
    commit();
    checks++;
    if (overwrite !== 1'b0) begin
      errors++; $display("FAIL ovw_first: got %0b want 0", overwrite);
    end
    commit();
    checks++;
    if (overwrite !== 1'b1) begin
      errors++; $display("FAIL ovw_second: got %0b want 1", overwrite);
    end
  endtask

  task automatic test_stop_edge();
    int s0;
    sbq.push_back('{m_pend, 1'b0});
    m_act = m_pend;
    m_valid = 0;
    pulse(1, 0, 0);
    tick(3);
    drain("stop_start");
    s0 = shut_cnt;
    stop = 1; time6s_sign = 1;
    tick();
    stop = 0;
    checks++;
    if (state_o !== 2'd0 || send_en !== 1'b0 || shut_time6s_sign !== 0) begin
      errors++; $display("FAIL stop_edge: got st=%0d en=%0b sh=%0b want 0",
                         state_o, send_en, shut_time6s_sign);
    end
    time6s_sign = 0;
    tick(3);
    checks++;
    if (shut_cnt - s0 !== 0 || message_flat !== m_act) begin
      errors++; $display("FAIL stop_keep: got shut=%0d want 0",
                         shut_cnt - s0);
    end
  endtask

  task automatic test_reset_run();
    write_word(0, 64'hCAFE_F00D_BAAD_0001);
    commit();
    sbq.push_back('{m_pend, 1'b0});
    m_act = m_pend;
    m_valid = 0;
    pulse(1, 0, 0);
    tick(3);
    drain("rr_start");
    rst = 1;
    tick();
    checks++;
    if (send_en !== 1'b0 || state_o !== 2'd0 || message_flat !== '0) begin
      errors++; $display("FAIL rst_run: got en=%0b st=%0d want 0/0",
                         send_en, state_o);
    end
    checks++;
    if (sv_num !== '0 || code_cnt_init !== '0 || overwrite !== 1'b0) begin
      errors++; $display("FAIL rst_run_cfg: got sv=%0d ovw=%0b want 0/0",
                         sv_num, overwrite);
    end
    rst = 0;
    m_pend = '0; m_act = '0; m_valid = 0;
    tick();
    host_wr(0, 32'd5);
    write_word(1, 64'h0F0F_F0F0_1234_ABCD);
    commit();
    sbq.push_back('{m_pend, 1'b0});
    m_act = m_pend;
    m_valid = 0;
    pulse(1, 0, 0);
    tick();
    checks++;
    if (send_en !== 1'b1 || sv_num !== 6'd5) begin
      errors++; $display("FAIL restart: got en=%0b sv=%0d want 1/5",
                         send_en, sv_num);
    end
    drain("restart");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_start();
    test_swap();
    test_underrun();
    test_commit_on_swap();
    test_cmd_err();
    test_overwrite();
    test_stop_edge();
    test_reset_run();
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/signal_gen_ctrl.md
SIGNAL_GEN_CTRL -- requirements
Module: signal_gen_ctrl

Interface
REQ-001 SHALL have parameter MSG_WORDS, default 5, number of 64-bit navigation message words per subframe.
REQ-002 SHALL have parameter AW, default 5, host register address width.
REQ-003 clk  input  1  sole clock, all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 wr_en / wr_addr / wr_data  input  1 / AW / 32  host register write strobe, address, data.
REQ-006 start / stop / msg_commit  input  1 each  single-cycle host commands.
REQ-007 time6s_sign  input  1  subframe-boundary flag from generator.
REQ-008 send_en  output  1  generator enable.
REQ-009 sv_num, fcarr_control, fcode_control  output  6 / 62 / 62  active channel config.
REQ-010 phase_init_carrier, phase_init_code  output  63 / 63  initial NCO phases.
REQ-011 phase_init_navidata, address_init_navidata, code_cnt_init  output  15 / 9 / 10  nav/code init.
REQ-012 message_flat  output  64*MSG_WORDS  active message; word k (message(k+1)) at bits [64k+63:64k].
REQ-013 shut_time6s_sign, msg_req  output  1 / 1  boundary acknowledge pulse, request for next subframe.
REQ-014 state_o, underrun, overwrite, cmd_err  output  2 / 1 / 1 / 1  FSM state, sticky error flags.

Function
REQ-015 Register map (32-bit words): 0 sv_num[5:0]; 1/2 fcarr lo/hi[29:0]; 3/4 fcode lo/hi[29:0]; 5/6 phase carrier lo/hi[30:0]; 7/8 phase code lo/hi[30:0]; 9 {code_cnt[9:0],address[8:0]}; 10 phase_navidata[14:0]; 11..20 pending message word lo/hi pairs; unused high bits ignored, other addresses ignored.
REQ-016 Config writes (addr 0-10) SHALL take effect only in IDLE; otherwise dropped and cmd_err set.
REQ-017 Pending message writes (11-20) SHALL be accepted in any state; msg_commit sets pending_valid.
REQ-018 msg_commit while pending_valid=1 SHALL set overwrite; pending_valid stays 1.
REQ-019 FSM states IDLE(0), LOAD(1), RUN(2), SWAP(3).
REQ-020 IDLE: send_en=0; start with pending_valid=1 -> LOAD; start with pending_valid=0 -> stay IDLE, set cmd_err.
REQ-021 LOAD (1 cycle): copy pending to active message, clear pending_valid, pulse msg_req; -> RUN; send_en=1 from first RUN cycle (2 cycles after start).
REQ-022 RUN: rising edge of time6s_sign (high now, low previous cycle) -> SWAP; level-high without edge SHALL NOT retrigger.
REQ-023 SWAP (1 cycle): if pending_valid copy pending->active and clear it, else keep active and set underrun; shut_time6s_sign=1 and msg_req=1 this cycle only; -> RUN; send_en stays 1.
REQ-024 stop SHALL take priority over start, edges and SWAP: from LOAD/RUN/SWAP -> IDLE next cycle, send_en=0 that cycle, active message retained, no shut pulse.
REQ-025 msg_commit in same cycle as LOAD/SWAP copy: copy uses prior buffer content, pending_valid ends 1.
REQ-026 Config outputs SHALL be constant while send_en=1.
REQ-027 Sticky flags clear only on rst or host write of 1 to address 31 bit0.

Reset
REQ-028 On rst: state IDLE; send_en, shut_time6s_sign, msg_req, flags, pending_valid = 0; all config, message, phase outputs = 0; edge-detect history = 0.
REQ-029 rst mid-RUN SHALL drop send_en in the cycle following assertion.

Structure
REQ-030 Package signal_gen_ctrl_pkg SHALL hold state enum, register address constants, MSG_WORDS default.
REQ-031 Pending/active message storage SHALL be sub-module msg_dbuf (write port, commit, copy, valid).

Verification
REQ-032 Write cfg (sv_num=3, fcarr=62'd301936306998477940), message 64'h22c05614257709a0 word0, commit, start -> send_en=1 two cycles later, outputs match, msg_req one pulse.
REQ-033 RUN, commit new msg, time6s_sign high 5 cycles -> one shut_time6s_sign pulse, one edge-later cycle, message_flat updated, underrun=0.
REQ-034 RUN, no commit, time6s_sign edge -> shut pulse, message unchanged, underrun=1.
REQ-035 start with no commit -> stays IDLE, cmd_err=1; write addr0 in RUN -> sv_num unchanged, cmd_err=1.
REQ-036 stop and time6s_sign edge same cycle -> IDLE, send_en=0, no shut pulse.
REQ-037 rst asserted in RUN -> all outputs 0 next cycle; restart sequence works.
